adrv9001_tx_framer: RTL and testbench

- Transmit-side SSI framer for one ADRV9001 TX channel.
- Accepts 32-bit IQ samples on AXI-stream and splits each sample into 8-bit I, Q and strobe words, two words per sample, for the TX output serdes.
- Owns the TX enable pin and the enable/disable sample delays.
- Sits between user DMA/DSP logic and the three per-lane output serdes, in the dclk_div domain.

---
 rtl/adrv9001_tx_framer.sv | 126 ++++++++++++
 tb/tb_adrv9001_tx_framer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_tx_framer.sv
// Transmit-side SSI framer for one ADRV9001 TX channel (dclk_div domain).
// Splits each 32-bit IQ sample into a two-cycle slot of I/Q/strobe bytes and owns the TX enable pin.
module adrv9001_tx_framer #(
  parameter int         DBG_EN       = 0,
  parameter logic [7:0] STROBE_WORD0 = 8'h80,
  parameter logic [7:0] STROBE_WORD1 = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        enable_mode,
  input  logic [15:0] enable_delay,
  input  logic [15:0] disable_delay,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  i_data,
  output logic [7:0]  q_data,
  output logic [7:0]  strobe,
  output logic        adrv9001_enable,
  output logic [15:0] underflow_cnt,
  output logic [31:0] dbg
);

  typedef enum logic [1:0] {IDLE, EN_WAIT, ACTIVE, DIS_WAIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        phase;
  logic        slot_live;
  logic [15:0] hold_lo;

  // Only the second-byte half of a sample needs holding; the first half goes straight out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase           <= 1'b0;
      state           <= IDLE;
      cnt             <= 16'd0;
      adrv9001_enable <= 1'b0;
    end else begin
      phase           <= ~phase;
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      adrv9001_enable <= enable_mode && (state != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (phase) begin
      case (state)
        IDLE: begin
          if (enable) begin
            cnt_nxt   = enable_delay;
            state_nxt = EN_WAIT;
          end
        end
        EN_WAIT: begin
          if (!enable)          state_nxt = IDLE;
          else if (cnt == 16'd0) state_nxt = ACTIVE;
          else                   cnt_nxt   = cnt - 16'd1;
        end
        ACTIVE: begin
          if (!enable) begin
            cnt_nxt   = disable_delay;
            state_nxt = DIS_WAIT;
          end
        end
        DIS_WAIT: begin
          if (enable)            state_nxt = ACTIVE;
          else if (cnt == 16'd0) state_nxt = IDLE;
          else                   cnt_nxt   = cnt - 16'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign s_axis_tready = phase && (state == ACTIVE || state == DIS_WAIT) && (state_nxt != IDLE);

  // An empty slot still emits strobes so the receiver stays word-aligned; its data is zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_data        <= 8'd0;
      q_data        <= 8'd0;
      strobe        <= 8'd0;
      hold_lo       <= 16'd0;
      slot_live     <= 1'b0;
      underflow_cnt <= 16'd0;
    end else if (s_axis_tready) begin
      slot_live <= 1'b1;
      strobe    <= STROBE_WORD0;
      if (s_axis_tvalid) begin
        i_data  <= s_axis_tdata[31:24];
        q_data  <= s_axis_tdata[15:8];
        hold_lo <= {s_axis_tdata[23:16], s_axis_tdata[7:0]};
      end else begin
        i_data  <= 8'd0;
        q_data  <= 8'd0;
        hold_lo <= 16'd0;
        if (underflow_cnt != 16'hFFFF)
          underflow_cnt <= underflow_cnt + 16'd1;
      end
    end else if (!phase && slot_live) begin
      slot_live <= 1'b0;
      i_data    <= hold_lo[15:8];
      q_data    <= hold_lo[7:0];
      strobe    <= STROBE_WORD1;
    end else begin
      slot_live <= 1'b0;
      i_data    <= 8'd0;
      q_data    <= 8'd0;
      strobe    <= 8'd0;
    end
  end

  generate
    if (DBG_EN != 0) begin : g_dbg
      assign dbg = {13'd0, state, phase, cnt};
    end else begin : g_no_dbg
      assign dbg = 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
// Bench for adrv9001_tx_framer: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and data expectations.
module tb_adrv9001_tx_framer;

  localparam logic [7:0] SW0 = 8'h80;
  localparam logic [7:0] SW1 = 8'h00;
  localparam int M_IDLE = 0, M_EN = 1, M_ACT = 2, M_DIS = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        enable_mode = 1'b1;
  logic [15:0] enable_delay = 16'd0;
  logic [15:0] disable_delay = 16'd0;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  i_data, q_data, strobe;
  logic        adrv9001_enable;
  logic [15:0] underflow_cnt;
  logic [31:0] dbg;

  int n_checks = 0;
  int n_errors = 0;

  adrv9001_tx_framer #(.DBG_EN(1), .STROBE_WORD0(SW0), .STROBE_WORD1(SW1)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .enable_mode(enable_mode),
    .enable_delay(enable_delay), .disable_delay(disable_delay),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .i_data(i_data), .q_data(q_data), .strobe(strobe),
    .adrv9001_enable(adrv9001_enable), .underflow_cnt(underflow_cnt), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: per-slot behaviour in plain integers.
  int          m_phase = 0, m_state = M_IDLE, m_cnt = 0, m_uf = 0;
  bit          m_live = 0, m_pin = 0;
  logic [31:0] m_hold = 0;
  logic [7:0]  e_i = 0, e_q = 0, e_s = 0;

  function automatic int model_next();
    case (m_state)
      M_IDLE:  return enable ? M_EN : M_IDLE;
      M_EN:    return !enable ? M_IDLE : (m_cnt == 0 ? M_ACT : M_EN);
      M_ACT:   return enable ? M_ACT : M_DIS;
      default: return enable ? M_ACT : (m_cnt == 0 ? M_IDLE : M_DIS);
    endcase
  endfunction

  function automatic bit model_ready();
    return (m_phase == 1) && (m_state == M_ACT || m_state == M_DIS) && (model_next() != M_IDLE);
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    int nxt;
    bit rdy;
    if (!rstn) begin
      m_phase = 0; m_state = M_IDLE; m_cnt = 0; m_uf = 0;
      m_live = 0; m_pin = 0; m_hold = 0; e_i = 0; e_q = 0; e_s = 0;
    end else begin
      nxt   = model_next();
      rdy   = model_ready();
      m_pin = enable_mode && (m_state != M_IDLE);
      if (m_phase == 1) begin
        if (rdy) begin
          m_live = 1;
          e_s    = SW0;
          m_hold = s_axis_tvalid ? s_axis_tdata : 32'd0;
          e_i    = m_hold[31:24];
          e_q    = m_hold[15:8];
          if (!s_axis_tvalid && m_uf < 65535) m_uf++;
        end else begin
          m_live = 0; e_i = 0; e_q = 0; e_s = 0;
        end
        if (m_state == M_IDLE && nxt == M_EN)      m_cnt = int'(enable_delay);
        else if (m_state == M_ACT && nxt == M_DIS) m_cnt = int'(disable_delay);
        else if (m_state == nxt && (nxt == M_EN || nxt == M_DIS)) m_cnt--;
        m_state = nxt;
      end else begin
        if (m_live) begin
          e_i = m_hold[23:16]; e_q = m_hold[7:0]; e_s = SW1;
        end else begin
          e_i = 0; e_q = 0; e_s = 0;
        end
        m_live = 0;
      end
      m_phase ^= 1;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check_output("tready", 32'(s_axis_tready), 32'(model_ready()));
      check_output("i_data", 32'(i_data), 32'(e_i));
      check_output("q_data", 32'(q_data), 32'(e_q));
      check_output("strobe", 32'(strobe), 32'(e_s));
      check_output("pin", 32'(adrv9001_enable), 32'(m_pin));
      check_output("underflow", 32'(underflow_cnt), 32'(m_uf));
    end
  end

  // Present one slot's data and return at the negedge just before it is taken.
  task automatic apply_stimulus(input logic [31:0] data, input logic valid);
    bit seen = 0;
    @(posedge clk); #1;
    s_axis_tdata  = data;
    s_axis_tvalid = valid;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = s_axis_tready;
    end
    check_output("slot_wait", 32'(seen), 32'd1);
  endtask

  logic [7:0] r_i[0:23], r_q[0:23], r_s[0:23];
  logic       r_pin[0:23], r_rdy[0:23];

  task automatic record(input int k);
    r_i[k] = i_data; r_q[k] = q_data; r_s[k] = strobe;
    r_pin[k] = adrv9001_enable; r_rdy[k] = s_axis_tready;
  endtask

  initial begin
    int first, n_acc, f;
    bit any, seen;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_i", 32'(i_data), 32'd0);
    check_output("rst_strobe", 32'(strobe), 32'd0);
    check_output("rst_pin", 32'(adrv9001_enable), 32'd0);
    check_output("rst_dbg", dbg, 32'd0);
    rstn = 1'b1;
    any = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      any |= s_axis_tready | (|i_data) | (|q_data) | (|strobe) | adrv9001_enable;
    end
    check_output("idle_quiet", 32'(any), 32'd0);

    // Enable with enable_delay=3, starting in a phase-0 cycle
    @(posedge clk); #1;
    while (m_phase != 0) begin @(posedge clk); #1; end
    enable_delay  = 16'd3;
    enable        = 1'b1;
    s_axis_tdata  = 32'hA1B2C3D4;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      record(k);
      if (k == 4) enable_delay = 16'd50;
    end
    check_output("pin_pre", 32'(r_pin[2]), 32'd0);
    check_output("pin_rise", 32'(r_pin[3]), 32'd1);
    first = -1;
    for (int k = 13; k >= 0; k--) if (r_rdy[k]) first = k;
    check_output("first_tready", 32'(first), 32'd11);
    check_output("b0_i", 32'(r_i[12]), 32'hA1);
    check_output("b0_q", 32'(r_q[12]), 32'hC3);
    check_output("b0_s", 32'(r_s[12]), 32'h80);
    check_output("b1_i", 32'(r_i[13]), 32'hB2);
    check_output("b1_q", 32'(r_q[13]), 32'hD4);
    check_output("b1_s", 32'(r_s[13]), 32'h00);

    // Ramp with a two-slot gap
    apply_stimulus(32'h10203040, 1'b1);
    apply_stimulus(32'h11213141, 1'b1);
    apply_stimulus(32'h12223242, 1'b1);
    apply_stimulus(32'h0, 1'b0);
    apply_stimulus(32'h0, 1'b0);
    apply_stimulus(32'h13233343, 1'b1);
    apply_stimulus(32'h14243444, 1'b1);
    check_output("uf_two", 32'(underflow_cnt), 32'd2);

    // Disable with disable_delay=2
    @(posedge clk); #1;
    enable        = 1'b0;
    disable_delay = 16'd2;
    s_axis_tdata  = 32'h15253545;
    n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      record(k);
      if (s_axis_tready) n_acc++;
      if (k == 2) disable_delay = 16'd9;
    end
    check_output("dis_accepts", 32'(n_acc), 32'd3);
    check_output("dis_no_rdy", 32'(r_rdy[7]), 32'd0);
    check_output("dis_last_s0", 32'(r_s[6]), 32'h80);
    check_output("dis_zero_s", 32'(r_s[8]), 32'h00);
    check_output("dis_zero_i", 32'(r_i[8]), 32'h00);
    check_output("pin_hold", 32'(r_pin[8]), 32'd1);
    check_output("pin_fall", 32'(r_pin[9]), 32'd0);
    check_output("uf_keep", 32'(underflow_cnt), 32'd2);

    // Re-enable during DIS_WAIT
    enable_delay  = 16'd0;
    disable_delay = 16'd5;
    enable        = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = s_axis_tready;
    end
    check_output("reen_wait", 32'(seen), 32'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (s_axis_tready) n_acc++;
      if (k == 4) enable = 1'b1;
    end
    check_output("cancel_no_gap", 32'(n_acc), 32'd7);

    // SPI enable mode: pin stays low, data unchanged
    enable = 1'b0;
    repeat (30) @(negedge clk);
    enable_mode   = 1'b0;
    enable_delay  = 16'd1;
    enable        = 1'b1;
    s_axis_tdata  = 32'h5A6B7C8D;
    any = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      record(k);
      any |= adrv9001_enable;
    end
    check_output("mode0_pin", 32'(any), 32'd0);
    f = -1;
    for (int k = 18; k >= 0; k--) if (r_s[k] == 8'h80) f = k;
    check_output("mode0_found", 32'(f >= 0), 32'd1);
    if (f >= 0) begin
      check_output("mode0_b0", {r_i[f], r_q[f]}, 32'h5A7C);
      check_output("mode0_b1", {r_i[f+1], r_q[f+1]}, 32'h6B8D);
    end

    // Asynchronous reset mid-sample
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = s_axis_tready;
    end
    check_output("mid_wait", 32'(seen), 32'd1);
    @(posedge clk); #2;
    check_output("mid_i", 32'(i_data), 32'h5A);
    enable = 1'b0;
    rstn   = 1'b0;
    #1;
    check_output("arst_i", 32'(i_data), 32'd0);
    check_output("arst_q", 32'(q_data), 32'd0);
    check_output("arst_s", 32'(strobe), 32'd0);
    check_output("arst_rdy", 32'(s_axis_tready), 32'd0);
    check_output("arst_uf", 32'(underflow_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    any = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any |= s_axis_tready | (|strobe);
    end
    check_output("post_quiet", 32'(any), 32'd0);
    check_output("post_uf", 32'(underflow_cnt), 32'd0);
    check_output("post_cnt", 32'(dbg[15:0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
